btb_predictor: RTL and testbench

- Direct-mapped branch target buffer with 2-bit saturating counters. Sits upstream of the fetch stage and feeds it.
- Combinational lookup on the fetch PC drives the fetch stage's hit_i and predicted_pc_i.
- Resolves branches arriving from EX: drives wrong_predicted_i and mispredicted_pc_i, and updates the table on the clock edge.

---
 rtl/btb_pkg.sv | 23 ++
 rtl/sat_counter2.sv | 19 +
 rtl/btb_predictor.sv | 131 +++++++++++++
 tb/tb_btb_predictor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer.
package btb_pkg;

  // Entry view: tag/target widths cover any INDEX_W; unused high tag bits read as zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [29:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_PC4  = 2'd1,
    RD_ALU  = 2'd2
  } redirect_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
  import btb_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup, EX resolution/update.
// Optional branch/mispredict statistics counters when BTB_STATS_EN is defined.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 32 - INDEX_W - 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  output logic        hit_o,
  output logic [31:0] predicted_pc_o,
  input  logic        ex_valid_i,
  input  logic        ex_branch_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_pc4_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_hit_i,
`ifdef BTB_STATS_EN
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispred_o,
`endif
  output logic [1:0]  wrong_predicted_o,
  output logic [31:0] mispredicted_pc_o
);

  localparam int ENTRIES = 1 << INDEX_W;

  // Control state (valid, ctr) is reset; tag/target payload is not.
  logic              valid_q  [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [29:0]       target_q [ENTRIES];

  logic [INDEX_W-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0]   f_tag, ex_tag;
  btb_entry_t         f_ent, ex_ent;
  logic               f_match, ex_match, resolve;
  redirect_e          redirect;
  logic [1:0]         ctr_nxt;

  assign f_idx   = pc_i[INDEX_W+1:2];
  assign f_tag   = pc_i[31:INDEX_W+2];
  assign ex_idx  = ex_pc_i[INDEX_W+1:2];
  assign ex_tag  = ex_pc_i[31:INDEX_W+2];
  assign resolve = ex_valid_i & ex_branch_i;

  always_comb begin
    f_ent.valid   = valid_q[f_idx];
    f_ent.tag     = 30'(tag_q[f_idx]);
    f_ent.target  = target_q[f_idx];
    f_ent.ctr     = ctr_q[f_idx];
    ex_ent.valid  = valid_q[ex_idx];
    ex_ent.tag    = 30'(tag_q[ex_idx]);
    ex_ent.target = target_q[ex_idx];
    ex_ent.ctr    = ctr_q[ex_idx];
  end

  assign f_match        = f_ent.valid & (f_ent.tag == 30'(f_tag));
  assign ex_match       = ex_ent.valid & (ex_ent.tag == 30'(ex_tag));
  assign hit_o          = f_match & f_ent.ctr[1];
  assign predicted_pc_o = hit_o ? {f_ent.target, 2'b00} : 32'd0;

  always_comb begin
    redirect = RD_NONE;
    if (resolve) begin
      if (ex_hit_i && !ex_taken_i) begin
        redirect = RD_PC4;
      end else if (ex_taken_i &&
                   (!ex_hit_i || !ex_match || ex_ent.target != ex_target_i[31:2])) begin
        redirect = RD_ALU;
      end
    end
  end

  assign wrong_predicted_o = redirect;
  assign mispredicted_pc_o = (redirect == RD_PC4) ? ex_pc4_i : 32'd0;

  sat_counter2 u_ctr (
    .ctr_i (ex_ent.ctr),
    .up_i  (ex_taken_i),
    .ctr_o (ctr_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (resolve) begin
      if (ex_match) begin
        ctr_q[ex_idx] <= ctr_nxt;
      end else if (ex_taken_i) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= WT;
      end
    end
  end

  // Payload is written on any taken resolution (refresh on match, fill on allocate).
  always_ff @(posedge clk_i) begin
    if (rst_ni && resolve && ex_taken_i) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= ex_target_i[31:2];
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] branches_q, mispred_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branches_q <= 32'd0;
      mispred_q  <= 32'd0;
    end else if (resolve) begin
      branches_q <= branches_q + 32'd1;
      if (redirect != RD_NONE) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_branches_o = branches_q;
  assign stat_mispred_o  = mispred_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{pc_i[1:0], ex_pc_i[1:0], ex_target_i[1:0], f_ent.ctr[0]};

endmodule

// File: tb/tb_btb_predictor.sv
// Randomized self-checking bench for btb_predictor against an array-based reference model.
module tb_btb_predictor;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] pc_i;
  logic        hit_o;
  logic [31:0] predicted_pc_o;
  logic        ex_valid_i, ex_branch_i, ex_taken_i, ex_hit_i;
  logic [31:0] ex_pc_i, ex_pc4_i, ex_target_i;
  logic [1:0]  wrong_predicted_o;
  logic [31:0] mispredicted_pc_o;
`ifdef BTB_STATS_EN
  logic [31:0] stat_branches_o, stat_mispred_o;
`endif

  always #5 clk_i = ~clk_i;

  btb_predictor dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .pc_i              (pc_i),
    .hit_o             (hit_o),
    .predicted_pc_o    (predicted_pc_o),
    .ex_valid_i        (ex_valid_i),
    .ex_branch_i       (ex_branch_i),
    .ex_taken_i        (ex_taken_i),
    .ex_pc_i           (ex_pc_i),
    .ex_pc4_i          (ex_pc4_i),
    .ex_target_i       (ex_target_i),
    .ex_hit_i          (ex_hit_i),
`ifdef BTB_STATS_EN
    .stat_branches_o   (stat_branches_o),
    .stat_mispred_o    (stat_mispred_o),
`endif
    .wrong_predicted_o (wrong_predicted_o),
    .mispredicted_pc_o (mispredicted_pc_o)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: 64 slots, target kept as a full word-aligned address, counter as 0..3.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  int unsigned m_tgt   [64];
  int          m_ctr   [64];

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic bit m_match(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 256);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_match(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  logic        obs_hit;
  logic [31:0] obs_pred, obs_mpc;
  logic [1:0]  obs_wp;

  // One clock: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic cycle(input logic [31:0] pc, input bit v, input bit br, input bit tk,
                       input logic [31:0] epc, input logic [31:0] tgt, input bit eh);
    bit          e_hit;
    logic [31:0] e_pred, e_mpc, tgt_w;
    int          e_wp, s;
    @(posedge clk_i);
    #1;
    pc_i = pc; ex_valid_i = v; ex_branch_i = br; ex_taken_i = tk;
    ex_pc_i = epc; ex_pc4_i = epc + 32'd4; ex_target_i = tgt; ex_hit_i = eh;
    @(negedge clk_i);
    tgt_w  = tgt & 32'hFFFF_FFFC;
    s      = slot(epc);
    e_hit  = m_hit(pc);
    e_pred = e_hit ? m_tgt[slot(pc)] : 32'd0;
    e_wp   = 0;
    if (v && br) begin
      if (eh && !tk) e_wp = 1;
      else if (tk && !eh) e_wp = 2;
      else if (tk && eh && (!m_match(epc) || m_tgt[s] != tgt_w)) e_wp = 2;
    end
    e_mpc = (e_wp == 1) ? epc + 32'd4 : 32'd0;
    obs_hit = hit_o; obs_pred = predicted_pc_o; obs_wp = wrong_predicted_o; obs_mpc = mispredicted_pc_o;
    check_val("hit", 32'(obs_hit), 32'(e_hit));
    check_val("pred_pc", obs_pred, e_pred);
    check_val("wrong_pred", 32'(obs_wp), 32'(e_wp));
    check_val("mispred_pc", obs_mpc, e_mpc);
    if (v && br) begin
      if (m_match(epc)) begin
        m_ctr[s] = tk ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1) : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
        if (tk) m_tgt[s] = tgt_w;
      end else if (tk) begin
        m_valid[s] = 1'b1; m_tag[s] = epc / 256; m_tgt[s] = tgt_w; m_ctr[s] = 2;
      end
    end
  endtask

  task automatic br_at(input logic [31:0] epc, input bit tk, input logic [31:0] tgt);
    cycle(epc, 1'b1, 1'b1, tk, epc, tgt, m_hit(epc));
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(pc, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(1, 4)) << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    logic [31:0] hot;
    m_reset();
    rst_ni = 1'b0; pc_i = 32'h100;
    ex_valid_i = 0; ex_branch_i = 0; ex_taken_i = 0; ex_hit_i = 0;
    ex_pc_i = 0; ex_pc4_i = 0; ex_target_i = 0;
    #12;
    check_val("rst_hit", 32'(hit_o), 32'd0);
    check_val("rst_pred", predicted_pc_o, 32'd0);
    check_val("rst_wp", 32'(wrong_predicted_o), 32'd0);
    check_val("rst_mpc", mispredicted_pc_o, 32'd0);
    #1 rst_ni = 1'b1;

    look(32'h100);
    check_val("tp_empty_hit", 32'(obs_hit), 32'd0);
    cycle(32'h100, 1, 1, 1, 32'h100, 32'h200, 0);
    check_val("tp_alloc_wp", 32'(obs_wp), 32'd2);
    look(32'h100);
    check_val("tp_alloc_hit", 32'(obs_hit), 32'd1);
    check_val("tp_alloc_pred", obs_pred, 32'h200);
    cycle(32'h100, 1, 1, 0, 32'h100, 32'h200, 1);
    check_val("tp_nt_wp", 32'(obs_wp), 32'd1);
    check_val("tp_nt_mpc", obs_mpc, 32'h104);
    check_val("tp_nt_prehit", 32'(obs_hit), 32'd1);
    look(32'h100);
    check_val("tp_nt_hit", 32'(obs_hit), 32'd0);

    repeat (4) br_at(32'h100, 1, 32'h200);
    repeat (2) br_at(32'h100, 0, 32'h200);
    look(32'h100);
    check_val("tp_sat_down_hit", 32'(obs_hit), 32'd0);
    br_at(32'h100, 1, 32'h200);
    look(32'h100);
    check_val("tp_sat_up_hit", 32'(obs_hit), 32'd1);

    br_at(32'h100, 1, 32'h200);
    cycle(32'h100, 1, 1, 1, 32'h100, 32'h300, 1);
    check_val("tp_tchg_wp", 32'(obs_wp), 32'd2);
    look(32'h100);
    check_val("tp_tchg_pred", obs_pred, 32'h300);

    br_at(32'h200, 1, 32'h400);
    check_val("tp_alias_wp", 32'(obs_wp), 32'd2);
    look(32'h100);
    check_val("tp_alias_old", 32'(obs_hit), 32'd0);
    look(32'h200);
    check_val("tp_alias_new", obs_pred, 32'h400);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] epc;
      epc = rand_pc();
      cycle(rand_pc(), $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
            epc, 32'($urandom_range(0, 15)) << 4 | 32'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1) ? m_hit(epc) : bit'($urandom_range(0, 1)));
    end

    hot = 32'h100;
    for (int t = 1; t <= 4; t++)
      for (int k = 0; k < 8; k++)
        if (m_hit((32'(t) << 8) | (32'(k) << 2))) hot = (32'(t) << 8) | (32'(k) << 2);
    @(posedge clk_i);
    #1;
    pc_i = hot; ex_valid_i = 1; ex_branch_i = 1; ex_taken_i = 1; ex_hit_i = 0;
    ex_pc_i = 32'h0000_A0C0; ex_pc4_i = 32'h0000_A0C4; ex_target_i = 32'h1000;
    #2 rst_ni = 1'b0;
    #1;
    check_val("midrst_hit", 32'(hit_o), 32'd0);
    check_val("midrst_pred", predicted_pc_o, 32'd0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    ex_valid_i = 0;
    m_reset();
    look(32'h0000_A0C0);
    check_val("midrst_dropped", 32'(obs_hit), 32'd0);
    look(hot);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
